// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and constants for the CPU memory-bus controller.
// Holds the bus command encoding, FSM state type, address region type and default map.
// Combinational helpers only; no state.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_RSVD  = 2'b11
    } mem_cmd_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        RGN_RAM  = 2'd0,
        RGN_LED  = 2'd1,
        RGN_SW   = 2'd2,
        RGN_NONE = 2'd3
    } region_e;

    localparam logic [8:0] LED_ADDR_DEF = 9'h100;
    localparam logic [8:0] SW_ADDR_DEF  = 9'h140;

    // RAM has priority so an LED/SW address placed inside the RAM window is shadowed.
    function automatic region_e decode_addr(
        input logic [8:0] addr,
        input logic [9:0] ram_limit,
        input logic [8:0] led_addr,
        input logic [8:0] sw_addr
    );
        region_e rgn;
        if ({1'b0, addr} < ram_limit) begin
            rgn = RGN_RAM;
        end else if (addr == led_addr) begin
            rgn = RGN_LED;
        end else if (addr == sw_addr) begin
            rgn = RGN_SW;
        end else begin
            rgn = RGN_NONE;
        end
        return rgn;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// CPU-side memory bus: command/address/store data in, registered load data out.
// Load data arrives one clock after the READ is sampled, flagged by rd_valid.
// No backpressure: the controller accepts one command every clock.
interface mem_bus_ctrl_if;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        rd_valid;

    modport master (
        output mem_cmd,
        output mem_addr,
        output write_data,
        input  read_data,
        input  rd_valid
    );

    modport slave (
        input  mem_cmd,
        input  mem_addr,
        input  write_data,
        output read_data,
        output rd_valid
    );
endinterface

// File: rtl/ram_256x16.sv
// Synchronous single-port 16-bit RAM, write-first on the read port.
// Read data registered one clock after en_i; write lands at the same edge.
// No backpressure; contents are never reset.
module ram_256x16 #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [15:0]   wdata_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [DEPTH];

    // Single port: a write also returns the new word so read-after-write sees it.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
                rdata_o       <= wdata_i;
            end else begin
                rdata_o <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU bus controller decoding a 9-bit word space into RAM, an LED register and a switch port.
// Reads return one clock after sampling (rd_valid pulse); writes complete at the sampling edge.
// No backpressure: back-to-back reads stream one result per clock.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int         RAM_DEPTH = 256,
    parameter logic [8:0] LED_ADDR  = LED_ADDR_DEF,
    parameter logic [8:0] SW_ADDR   = SW_ADDR_DEF
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_ctrl_if.slave     bus,
    input  logic [7:0]        sw,
    output logic [7:0]        led,
    output logic              bus_err
);

    localparam int         RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [9:0] RAM_LIMIT = 10'(RAM_DEPTH);

    state_e      state_q;
    logic [8:0]  rd_addr_q;
    logic [15:0] read_data_q;
    logic        rd_valid_q;
    logic [7:0]  led_q;
    logic        bus_err_q;
    logic [7:0]  sw_meta_q;
    logic [7:0]  sw_sync_q;

    mem_cmd_e    cmd;
    region_e     cur_rgn;
    region_e     rd_rgn;
    logic        is_rd;
    logic        is_wr;
    logic        ram_we;
    logic        ram_en;
    logic [15:0] ram_rdata;
    logic [15:0] read_data_d;
    logic        err_d;

    assign cmd     = mem_cmd_e'(bus.mem_cmd);
    assign is_rd   = (cmd == CMD_READ);
    assign is_wr   = (cmd == CMD_WRITE);
    assign cur_rgn = decode_addr(bus.mem_addr, RAM_LIMIT, LED_ADDR, SW_ADDR);
    assign rd_rgn  = decode_addr(rd_addr_q, RAM_LIMIT, LED_ADDR, SW_ADDR);

    // The RAM is read at the sampling edge so its word is ready for the RD_WAIT edge.
    assign ram_we = is_wr && (cur_rgn == RGN_RAM);
    assign ram_en = is_rd || ram_we;

    ram_256x16 #(
        .DEPTH (RAM_DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (bus.mem_addr[RAM_AW-1:0]),
        .wdata_i (bus.write_data),
        .rdata_o (ram_rdata)
    );

    // Load result for the captured address; unmapped space reads as zero.
    always_comb begin
        read_data_d = 16'h0000;
        case (rd_rgn)
            RGN_RAM: read_data_d = ram_rdata;
            RGN_LED: read_data_d = {8'h00, led_q};
            RGN_SW:  read_data_d = {8'h00, sw_sync_q};
            default: read_data_d = 16'h0000;
        endcase
    end

    // Illegal accesses: reserved command, store to switches/unmapped, load from unmapped.
    always_comb begin
        err_d = 1'b0;
        if (cmd == CMD_RSVD) begin
            err_d = 1'b1;
        end
        if (is_wr && ((cur_rgn == RGN_SW) || (cur_rgn == RGN_NONE))) begin
            err_d = 1'b1;
        end
        if (is_rd && (cur_rgn == RGN_NONE)) begin
            err_d = 1'b1;
        end
    end

    // Bus FSM, LED register, sticky error and switch synchroniser.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= 9'h000;
            read_data_q <= 16'h0000;
            rd_valid_q  <= 1'b0;
            led_q       <= 8'h00;
            bus_err_q   <= 1'b0;
            sw_meta_q   <= 8'h00;
            sw_sync_q   <= 8'h00;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;

            rd_valid_q <= (state_q == ST_RD_WAIT);
            if (state_q == ST_RD_WAIT) begin
                read_data_q <= read_data_d;
            end

            // A fresh READ keeps us in RD_WAIT so results stream every clock.
            if (is_rd) begin
                rd_addr_q <= bus.mem_addr;
                state_q   <= ST_RD_WAIT;
            end else begin
                state_q   <= ST_IDLE;
            end

            if (is_wr && (cur_rgn == RGN_LED)) begin
                led_q <= bus.write_data[7:0];
            end

            if (err_d) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    assign bus.read_data = read_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign led           = led_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: reset, RAM/LED/switch access, streaming reads,
// error flagging and reset during a pending read. Inputs driven 1ns after posedge,
// outputs checked at the same point, i.e. after the edge that produced them.
module tb_mem_bus_ctrl;
    import mem_bus_pkg::*;

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_RD   = 2'b01;
    localparam logic [1:0] C_WR   = 2'b10;
    localparam logic [1:0] C_RSV  = 2'b11;

    logic       clk;
    logic       reset;
    logic [7:0] sw;
    logic [7:0] led;
    logic       bus_err;
    int         checks = 0;
    int         errors = 0;

    mem_bus_ctrl_if bus();

    mem_bus_ctrl #(
        .RAM_DEPTH (256),
        .LED_ADDR  (9'h100),
        .SW_ADDR   (9'h140)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .sw      (sw),
        .led     (led),
        .bus_err (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command for exactly one sampling edge, then return to NONE.
    task automatic drive(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        bus.mem_cmd    = c;
        bus.mem_addr   = a;
        bus.write_data = d;
        tick();
        bus.mem_cmd    = C_NONE;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (bus.read_data !== 16'h0000) begin errors++; $display("FAIL reset_read_data: got %h expected %h", bus.read_data, 16'h0000); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", led); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b expected 0", bus_err); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_ram_rw();
        drive(C_WR, 9'h005, 16'h00AB);
        drive(C_RD, 9'h005, 16'h0000);
        tick();
        checks++; if (bus.read_data !== 16'h00AB) begin errors++; $display("FAIL ram_raw_data: got %h expected 00ab", bus.read_data); end
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL ram_raw_valid: got %b expected 1", bus.rd_valid); end
        tick();
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL ram_valid_one_cycle: got %b expected 0", bus.rd_valid); end
        checks++; if (bus.read_data !== 16'h00AB) begin errors++; $display("FAIL ram_data_hold: got %h expected 00ab", bus.read_data); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL ram_no_err: got %b expected 0", bus_err); end
    endtask

    task automatic test_led();
        drive(C_WR, 9'h100, 16'h1234);
        checks++; if (led !== 8'h34) begin errors++; $display("FAIL led_write: got %h expected 34", led); end
        drive(C_RD, 9'h100, 16'h0000);
        tick();
        checks++; if (bus.read_data !== 16'h0034) begin errors++; $display("FAIL led_read: got %h expected 0034", bus.read_data); end
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL led_read_valid: got %b expected 1", bus.rd_valid); end
    endtask

    task automatic test_back_to_back();
        drive(C_WR, 9'h000, 16'h0001);
        drive(C_WR, 9'h001, 16'h0002);
        drive(C_WR, 9'h002, 16'h0003);
        drive(C_RD, 9'h000, 16'h0000);
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_early: got %b expected 0", bus.rd_valid); end
        drive(C_RD, 9'h001, 16'h0000);
        checks++; if ({bus.rd_valid, bus.read_data} !== {1'b1, 16'h0001}) begin errors++; $display("FAIL b2b_first: got %b/%h expected 1/0001", bus.rd_valid, bus.read_data); end
        drive(C_RD, 9'h002, 16'h0000);
        checks++; if ({bus.rd_valid, bus.read_data} !== {1'b1, 16'h0002}) begin errors++; $display("FAIL b2b_second: got %b/%h expected 1/0002", bus.rd_valid, bus.read_data); end
        tick();
        checks++; if ({bus.rd_valid, bus.read_data} !== {1'b1, 16'h0003}) begin errors++; $display("FAIL b2b_third: got %b/%h expected 1/0003", bus.rd_valid, bus.read_data); end
        tick();
        checks++; if ({bus.rd_valid, bus.read_data} !== {1'b0, 16'h0003}) begin errors++; $display("FAIL b2b_end: got %b/%h expected 0/0003", bus.rd_valid, bus.read_data); end
    endtask

    task automatic test_switch();
        sw = 8'h5A;
        tick();
        tick();
        tick();
        drive(C_RD, 9'h140, 16'h0000);
        tick();
        checks++; if (bus.read_data !== 16'h005A) begin errors++; $display("FAIL sw_read: got %h expected 005a", bus.read_data); end
        // Change arrives at the synchroniser input; a read sampled one edge later still sees the old value.
        sw = 8'hC3;
        drive(C_RD, 9'h140, 16'h0000);
        drive(C_RD, 9'h140, 16'h0000);
        checks++; if (bus.read_data !== 16'h005A) begin errors++; $display("FAIL sw_sync_old: got %h expected 005a", bus.read_data); end
        tick();
        checks++; if (bus.read_data !== 16'h00C3) begin errors++; $display("FAIL sw_sync_new: got %h expected 00c3", bus.read_data); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL sw_err_before: got %b expected 0", bus_err); end
        drive(C_WR, 9'h140, 16'hFFFF);
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL sw_write_err: got %b expected 1", bus_err); end
        for (int i = 0; i < 5; i++) begin
            drive(C_WR, 9'(9'h010 + i), 16'(i));
        end
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", bus_err); end
        drive(C_RD, 9'h012, 16'h0000);
        tick();
        checks++; if ({bus_err, bus.read_data} !== {1'b1, 16'h0002}) begin errors++; $display("FAIL err_sticky_read: got %b/%h expected 1/0002", bus_err, bus.read_data); end
    endtask

    task automatic test_unmapped();
        do_reset();
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL err_cleared_by_reset: got %b expected 0", bus_err); end
        drive(C_RSV, 9'h000, 16'h0000);
        tick();
        checks++; if ({bus_err, bus.rd_valid} !== 2'b10) begin errors++; $display("FAIL rsvd_cmd: got err/valid %b/%b expected 1/0", bus_err, bus.rd_valid); end
        do_reset();
        drive(C_RD, 9'h005, 16'h0000);
        tick();
        checks++; if (bus.read_data !== 16'h00AB) begin errors++; $display("FAIL ram_survives_reset: got %h expected 00ab", bus.read_data); end
        drive(C_RD, 9'h1F0, 16'h0000);
        tick();
        checks++; if ({bus_err, bus.rd_valid, bus.read_data} !== {1'b1, 1'b1, 16'h0000}) begin errors++; $display("FAIL unmapped_read: got err/valid/data %b/%b/%h expected 1/1/0000", bus_err, bus.rd_valid, bus.read_data); end
        do_reset();
        drive(C_WR, 9'h0FF, 16'hCAFE);
        drive(C_RD, 9'h0FF, 16'h0000);
        tick();
        checks++; if ({bus_err, bus.read_data} !== {1'b0, 16'hCAFE}) begin errors++; $display("FAIL ram_last_word: got err/data %b/%h expected 0/cafe", bus_err, bus.read_data); end
        drive(C_WR, 9'h1FF, 16'hFFFF);
        checks++; if ({bus_err, led} !== {1'b1, 8'h00}) begin errors++; $display("FAIL unmapped_write_1ff: got err/led %b/%h expected 1/00", bus_err, led); end
    endtask

    task automatic test_reset_in_rd_wait();
        do_reset();
        drive(C_WR, 9'h100, 16'h0077);
        drive(C_WR, 9'h009, 16'hBEEF);
        drive(C_RD, 9'h005, 16'h0000);
        tick();
        checks++; if ({led, bus.read_data} !== {8'h77, 16'h00AB}) begin errors++; $display("FAIL pre_reset_state: got led/data %h/%h expected 77/00ab", led, bus.read_data); end
        drive(C_RD, 9'h009, 16'h0000);
        reset = 1'b1;
        #2;
        checks++; if ({bus.rd_valid, bus.read_data, led} !== {1'b0, 16'h0000, 8'h00}) begin errors++; $display("FAIL async_reset_rd_wait: got valid/data/led %b/%h/%h expected 0/0000/00", bus.rd_valid, bus.read_data, led); end
        tick();
        reset = 1'b0;
        tick();
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL no_pulse_after_reset_1: got %b expected 0", bus.rd_valid); end
        tick();
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL no_pulse_after_reset_2: got %b expected 0", bus.rd_valid); end
        drive(C_RD, 9'h009, 16'h0000);
        tick();
        checks++; if ({bus.rd_valid, bus.read_data} !== {1'b1, 16'hBEEF}) begin errors++; $display("FAIL ram_intact_after_reset: got %b/%h expected 1/beef", bus.rd_valid, bus.read_data); end
    endtask

    initial begin
        reset          = 1'b1;
        sw             = 8'h00;
        bus.mem_cmd    = C_NONE;
        bus.mem_addr   = 9'h000;
        bus.write_data = 16'h0000;
        test_reset();
        test_ram_rw();
        test_led();
        test_back_to_back();
        test_switch();
        test_unmapped();
        test_reset_in_rd_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter RAM_DEPTH, default 256, number of 16-bit RAM words mapped from address 9'h000.
REQ-002 Parameter LED_ADDR, default 9'h100, address of the LED output register.
REQ-003 Parameter SW_ADDR, default 9'h140, address of the read-only switch port.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 mem_cmd  input  2  CPU bus command: 00 NONE, 01 READ, 10 WRITE, 11 reserved.
REQ-008 mem_addr  input  9  CPU word address.
REQ-009 write_data  input  16  CPU store data.
REQ-010 read_data  output  16  registered load data returned to the CPU.
REQ-011 rd_valid  output  1  high for exactly one cycle when read_data carries a new load result.
REQ-012 sw  input  8  asynchronous board switches.
REQ-013 led  output  8  LED register.
REQ-014 bus_err  output  1  sticky error flag.

Function
REQ-015 The FSM SHALL have states IDLE and RD_WAIT.
REQ-016 READ sampled in any state: capture mem_addr, next state RD_WAIT.
REQ-017 In RD_WAIT: read_data updated from the captured address; rd_valid=1 for that cycle; next state IDLE unless a new READ is sampled, which keeps RD_WAIT (back-to-back reads, one result per cycle).
REQ-018 Read latency SHALL be exactly one clock: command sampled at edge k, data and rd_valid visible after edge k+1.
REQ-019 WRITE SHALL complete at the edge where it is sampled, in any state; rd_valid is not asserted.
REQ-020 Write decode: addr < RAM_DEPTH -> RAM word; addr == LED_ADDR -> led <= write_data[7:0]; SW_ADDR or unmapped -> data discarded, bus_err <= 1.
REQ-021 Read decode: RAM -> stored word; SW_ADDR -> {8'h00, synchronised sw}; LED_ADDR -> {8'h00, led}; unmapped -> 16'h0000 with bus_err <= 1.
REQ-022 mem_cmd 11 SHALL act as NONE and set bus_err.
REQ-023 A READ at edge k+1 of an address written at edge k SHALL return the new data.
REQ-024 read_data SHALL hold its last value while rd_valid is low.
REQ-025 sw SHALL pass through a 2-flop synchroniser; a switch change is readable no earlier than 2 edges later.
REQ-026 bus_err SHALL remain 1 until reset; later legal accesses do not clear it.
REQ-027 Address 9'h1FF and every address between RAM_DEPTH and 9'h1FF, other than LED_ADDR and SW_ADDR, SHALL be treated as unmapped.

Reset
REQ-028 Reset SHALL force: state IDLE, read_data 16'h0000, rd_valid 0, led 8'h00, bus_err 0, synchroniser flops 0.
REQ-029 Reset asserted during RD_WAIT SHALL drop the pending read; rd_valid SHALL NOT pulse for it after release.
REQ-030 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-031 Package mem_bus_pkg SHALL hold the mem_cmd encoding, the FSM state type, and the default LED_ADDR/SW_ADDR constants.
REQ-032 The RAM SHALL be one sub-module, ram_256x16: synchronous single-port, write-first, 16-bit.

Verification
REQ-033 WRITE 16'h00AB to 9'h005, then READ 9'h005 the next cycle -> one cycle later read_data=16'h00AB, rd_valid=1 for one cycle.
REQ-034 WRITE 16'h1234 to LED_ADDR -> led=8'h34; READ LED_ADDR -> read_data=16'h0034.
REQ-035 sw=8'h5A held 3 cycles, READ SW_ADDR -> read_data=16'h005A; WRITE to SW_ADDR -> bus_err=1, still 1 after 5 legal accesses.
REQ-036 Back-to-back READs 9'h000, 9'h001, 9'h002 preloaded 1,2,3 -> rd_valid high 3 consecutive cycles, read_data 1,2,3.
REQ-037 READ 9'h1F0 -> read_data=16'h0000, bus_err=1; mem_cmd=11 after reset -> bus_err=1.
REQ-038 Reset pulsed in RD_WAIT -> rd_valid=0, read_data=0, led=0; RAM word written before reset still reads back intact.
